// File: rtl/cg_iteration_ctrl_if.sv
// Handshake and data bundle between the conjugate-gradient datapath stages
// and the iteration controller.
//
// master modport : datapath / sequencer side (drives starts, finishes, data)
// slave modport  : cg_iteration_ctrl (drives stage_reset, div2_start,
//                  captured rsold/rsnew, iteration count and status)
interface cg_iteration_ctrl_if #(
    parameter int ITER_W = 16
) ();
    logic              solve_start;
    logic              abort;
    logic              rsold_finish;
    logic [31:0]       rsold_in;
    logic              rsnew_finish;
    logic [31:0]       rsnew_in;
    logic              p_update_finish;
    logic              stage_reset;
    logic              div2_start;
    logic [31:0]       rsold_out;
    logic [31:0]       rsnew_out;
    logic [ITER_W-1:0] iteration_count;
    logic              busy;
    logic              done;
    logic              converged;
    logic              max_iter_reached;
    logic              nan_error;

    modport master (
        output solve_start, abort, rsold_finish, rsold_in, rsnew_finish,
               rsnew_in, p_update_finish,
        input  stage_reset, div2_start, rsold_out, rsnew_out, iteration_count,
               busy, done, converged, max_iter_reached, nan_error
    );

    modport slave (
        input  solve_start, abort, rsold_finish, rsold_in, rsnew_finish,
               rsnew_in, p_update_finish,
        output stage_reset, div2_start, rsold_out, rsnew_out, iteration_count,
               busy, done, converged, max_iter_reached, nan_error
    );
endinterface

// File: rtl/cg_iteration_ctrl.sv
// Iteration sequencer and convergence checker for the conjugate-gradient
// solver. Waits for the r.r dot products (rsold on the first iteration only,
// rsnew every iteration), tests rsnew against a float32 tolerance, kicks the
// beta divider and waits for the p-vector update before re-launching the
// datapath stages for the next iteration.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-low reset
//   ctrl   - cg_iteration_ctrl_if.slave: solve_start/abort control, the three
//            *_finish levels with rsold/rsnew data, and the stage_reset,
//            div2_start, captured rsold/rsnew, iteration_count, busy and
//            done/converged/max_iter_reached/nan_error outputs.
module cg_iteration_ctrl #(
    parameter logic [31:0] TOLERANCE          = 32'h283424DC,
    parameter int          MAX_ITER           = 64,
    parameter int          ITER_W             = 16,
    parameter int          STAGE_RESET_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    cg_iteration_ctrl_if.slave ctrl
);
    localparam int SR_W = (STAGE_RESET_CYCLES > 1) ? $clog2(STAGE_RESET_CYCLES) : 1;
    localparam logic [SR_W-1:0]   SR_LAST   = SR_W'(STAGE_RESET_CYCLES - 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);
    localparam logic [30:0]       TOL_MAG   = TOLERANCE[30:0];

    // Bit positions of the three finish inputs in the edge-detect vectors.
    localparam int EV_RSOLD = 0;
    localparam int EV_RSNEW = 1;
    localparam int EV_PUPD  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_ITER,
        S_WAIT_RSOLD,
        S_WAIT_RSNEW,
        S_CHECK,
        S_WAIT_PUPD,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [SR_W-1:0]   sr_cnt_reg, sr_cnt_next;
    logic [2:0]        finish_in, finish_d_reg, evt, flag_reg, flag_next;
    logic              stage_reset_reg, div2_start_reg;
    logic [31:0]       rsold_reg, rsnew_reg;
    logic [ITER_W-1:0] iter_reg;
    logic              done_reg, converged_reg, max_iter_reg, nan_reg;

    logic start_solve, set_nan, set_conv, set_max, fire_div, advance;
    logic rsnew_is_nan, rsnew_below_tol, at_last_iter, capture_ok;

    assign finish_in = {ctrl.p_update_finish, ctrl.rsnew_finish, ctrl.rsold_finish};

    // Rising-edge events and sticky capture flags. A flag raised before its
    // wait state is reached is remembered; START_ITER wipes the previous
    // iteration's flags but still accepts an edge landing in that same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_finish
            assign evt[gi] = finish_in[gi] & ~finish_d_reg[gi];
            assign flag_next[gi] =
                (state_reg == S_IDLE || state_next == S_IDLE) ? 1'b0 :
                (state_reg == S_START_ITER)                  ? evt[gi] :
                                                               (flag_reg[gi] | evt[gi]);
        end
    endgenerate

    // CHECK rules operate on the registered rsnew; the sign bit is ignored so
    // that -0 converges just like +0.
    assign rsnew_is_nan    = (rsnew_reg[30:23] == 8'hFF) && (rsnew_reg[22:0] != 23'd0);
    assign rsnew_below_tol = rsnew_reg[30:0] < TOL_MAG;
    assign at_last_iter    = (iter_reg == LAST_ITER);
    assign capture_ok      = (state_reg != S_IDLE) && !ctrl.abort;

    always_comb begin
        state_next  = state_reg;
        sr_cnt_next = '0;
        start_solve = 1'b0;
        set_nan     = 1'b0;
        set_conv    = 1'b0;
        set_max     = 1'b0;
        fire_div    = 1'b0;
        advance     = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (ctrl.solve_start) begin
                    start_solve = 1'b1;
                    state_next  = S_START_ITER;
                end
            end
            S_START_ITER: begin
                if (sr_cnt_reg == SR_LAST) begin
                    // Only the first iteration needs a fresh rsold; later ones
                    // carry the previous rsnew forward.
                    state_next = (iter_reg == '0) ? S_WAIT_RSOLD : S_WAIT_RSNEW;
                end else begin
                    sr_cnt_next = sr_cnt_reg + SR_W'(1);
                end
            end
            S_WAIT_RSOLD: begin
                if (flag_reg[EV_RSOLD]) state_next = S_WAIT_RSNEW;
            end
            S_WAIT_RSNEW: begin
                if (flag_reg[EV_RSNEW]) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (rsnew_is_nan) begin
                    set_nan    = 1'b1;
                    state_next = S_DONE;
                end else if (rsnew_below_tol) begin
                    set_conv   = 1'b1;
                    state_next = S_DONE;
                end else if (at_last_iter) begin
                    set_max    = 1'b1;
                    state_next = S_DONE;
                end else begin
                    fire_div   = 1'b1;
                    state_next = S_WAIT_PUPD;
                end
            end
            S_WAIT_PUPD: begin
                if (flag_reg[EV_PUPD]) begin
                    advance    = 1'b1;
                    state_next = S_START_ITER;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Abort overrides everything, including a coincident solve_start.
        if (ctrl.abort) begin
            state_next  = S_IDLE;
            sr_cnt_next = '0;
            start_solve = 1'b0;
            set_nan     = 1'b0;
            set_conv    = 1'b0;
            set_max     = 1'b0;
            fire_div    = 1'b0;
            advance     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            sr_cnt_reg      <= '0;
            finish_d_reg    <= '0;
            flag_reg        <= '0;
            stage_reset_reg <= 1'b0;
            div2_start_reg  <= 1'b0;
            rsold_reg       <= '0;
            rsnew_reg       <= '0;
            iter_reg        <= '0;
            done_reg        <= 1'b0;
            converged_reg   <= 1'b0;
            max_iter_reg    <= 1'b0;
            nan_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sr_cnt_reg      <= sr_cnt_next;
            finish_d_reg    <= finish_in;
            flag_reg        <= flag_next;
            stage_reset_reg <= (state_next == S_START_ITER);
            div2_start_reg  <= fire_div;
            done_reg        <= (state_next == S_DONE);

            if (ctrl.abort || start_solve) begin
                converged_reg <= 1'b0;
                max_iter_reg  <= 1'b0;
                nan_reg       <= 1'b0;
            end else begin
                if (set_conv) converged_reg <= 1'b1;
                if (set_max)  max_iter_reg  <= 1'b1;
                if (set_nan)  nan_reg       <= 1'b1;
            end

            if (start_solve) begin
                iter_reg <= '0;
            end else if (advance && (iter_reg != '1)) begin
                iter_reg <= iter_reg + ITER_W'(1);
            end

            // Carrying rsnew into rsold at the end of an iteration takes
            // precedence over a stray rsold edge in the same cycle.
            if (advance) begin
                rsold_reg <= rsnew_reg;
            end else if (capture_ok && evt[EV_RSOLD]) begin
                rsold_reg <= ctrl.rsold_in;
            end
            if (capture_ok && evt[EV_RSNEW]) begin
                rsnew_reg <= ctrl.rsnew_in;
            end
        end
    end

    assign ctrl.stage_reset      = stage_reset_reg;
    assign ctrl.div2_start       = div2_start_reg;
    assign ctrl.rsold_out        = rsold_reg;
    assign ctrl.rsnew_out        = rsnew_reg;
    assign ctrl.iteration_count  = iter_reg;
    assign ctrl.done             = done_reg;
    assign ctrl.converged        = converged_reg;
    assign ctrl.max_iter_reached = max_iter_reg;
    assign ctrl.nan_error        = nan_reg;
    assign ctrl.busy             = (state_reg != S_IDLE) && (state_reg != S_DONE);
endmodule

// File: tb/tb_cg_iteration_ctrl.sv
// Self-checking bench for cg_iteration_ctrl. A behavioural model predicts the
// outcome of a whole solve from the sequence of rsnew values; the bench plays
// the datapath role and compares status, counts, captured values and timing.
module tb_cg_iteration_ctrl;
    localparam int          MAX_ITER = 4;
    localparam int          ITER_W   = 16;
    localparam int          SRC      = 2;
    localparam logic [31:0] TOL      = 32'h283424DC;
    localparam int          BUDGET   = 40;
    localparam int          OW       = ITER_W + 71;
    localparam int K_CONV = 0, K_MAX = 1, K_NAN = 2, K_NONE = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cg_iteration_ctrl_if #(.ITER_W(ITER_W)) bus ();

    cg_iteration_ctrl #(
        .TOLERANCE(TOL), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .STAGE_RESET_CYCLES(SRC)
    ) dut (
        .clk(clk), .reset(reset), .ctrl(bus)
    );

    always #5 clk = ~clk;

    // Observations collected while driving a solve.
    int          obs_div_cnt = 0;
    logic        obs_start_sr;
    logic [31:0] obs_old[$];
    logic [31:0] obs_new[$];
    int          obs_sr_len[$];
    int          obs_lat[$];

    // Model predictions.
    int          exp_kind, exp_iters;
    logic [31:0] exp_old[$];
    logic [31:0] exp_new[$];
    logic [31:0] exp_rsold_fin, exp_rsnew_fin;

    function automatic logic [OW-1:0] outs();
        return {bus.stage_reset, bus.div2_start, bus.rsold_out, bus.rsnew_out,
                bus.iteration_count, bus.busy, bus.done, bus.converged,
                bus.max_iter_reached, bus.nan_error};
    endfunction

    function automatic bit is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic int unsigned mag(input logic [31:0] v);
        return {1'b0, v[30:0]};
    endfunction

    function automatic logic [31:0] rand_large();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(8'h51, 8'hFE)), 23'($urandom)};
    endfunction

    function automatic logic [31:0] rand_val();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0:       return {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            1:       return {s, 8'hFF, 23'h0};
            2:       return {s, 31'($urandom_range(0, 32'h283424DB))};
            3:       return {s, 31'h283424DC};
            default: return rand_large();
        endcase
    endfunction

    // Walk the solve as the algorithm describes it: each iteration judges
    // rsnew; a continuing iteration hands (carried rsold, rsnew) to the divider.
    task automatic model(input logic [31:0] rsold, input logic [31:0] rs[$]);
        logic [31:0] carried;
        logic [31:0] v;
        carried = rsold;
        exp_kind = K_NONE;
        exp_iters = 0;
        exp_old.delete();
        exp_new.delete();
        exp_rsold_fin = carried;
        exp_rsnew_fin = '0;
        for (int k = 0; k < rs.size(); k++) begin
            v = rs[k];
            exp_iters = k;
            exp_rsold_fin = carried;
            exp_rsnew_fin = v;
            if (is_nan(v)) begin exp_kind = K_NAN; return; end
            if (mag(v) < mag(TOL)) begin exp_kind = K_CONV; return; end
            if (k == MAX_ITER - 1) begin exp_kind = K_MAX; return; end
            exp_old.push_back(carried);
            exp_new.push_back(v);
            carried = v;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.div2_start) obs_div_cnt++;
    endtask

    // Raise the selected finish levels for two cycles, then drop them and put
    // junk on the data inputs so only edge-time data can be captured.
    task automatic pulse(input bit p_old, input bit p_new, input bit p_upd,
                         input logic [31:0] v_old, input logic [31:0] v_new);
        bus.rsold_finish    = p_old;
        bus.rsnew_finish    = p_new;
        bus.p_update_finish = p_upd;
        if (p_old) bus.rsold_in = v_old;
        if (p_new) bus.rsnew_in = v_new;
        tick();
        tick();
        bus.rsold_finish    = 1'b0;
        bus.rsnew_finish    = 1'b0;
        bus.p_update_finish = 1'b0;
        bus.rsold_in        = $urandom;
        bus.rsnew_in        = $urandom;
    endtask

    // order: 0 rsold then rsnew, 1 rsnew then rsold, 2 both together.
    task automatic drive_solve(input logic [31:0] rsold, input logic [31:0] rs[$], input int order,
                               input int stop_iter, input int abort_iter);
        int b;
        int len;
        obs_div_cnt = 0;
        obs_old.delete(); obs_new.delete(); obs_sr_len.delete(); obs_lat.delete();
        bus.solve_start = 1'b1;
        tick();
        bus.solve_start = 1'b0;
        obs_start_sr = bus.stage_reset;
        for (int k = 0; k < rs.size(); k++) begin
            b = 0;
            while (!bus.stage_reset && b < BUDGET) begin tick(); b++; end
            len = 0;
            while (bus.stage_reset && len < BUDGET) begin len++; tick(); end
            obs_sr_len.push_back(len);
            if (k == stop_iter) return;
            if (k == 0) begin
                case (order)
                    0:       begin pulse(1, 0, 0, rsold, '0); pulse(0, 1, 0, '0, rs[k]); end
                    1:       begin pulse(0, 1, 0, '0, rs[k]); pulse(1, 0, 0, rsold, '0); end
                    default: pulse(1, 1, 0, rsold, rs[k]);
                endcase
            end else begin
                pulse(0, 1, 0, '0, rs[k]);
            end
            b = 0;
            while (!bus.done && !bus.div2_start && b < BUDGET) begin tick(); b++; end
            obs_lat.push_back(b);
            checks++;
            if (b >= BUDGET) begin
                errors++;
                $display("FAIL check_timeout iter %0d got no done/div2_start within %0d cycles", k, BUDGET);
                return;
            end
            if (bus.done) return;
            obs_old.push_back(bus.rsold_out);
            obs_new.push_back(bus.rsnew_out);
            if (k == abort_iter) begin
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                return;
            end
            pulse(0, 0, 1, '0, '0);
        end
        checks++;
        errors++;
        $display("FAIL no_done got done=%0b after %0d rsnew values exp done=1", bus.done, rs.size());
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (outs() !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs()); end
        reset = 1'b1;
        tick();
        checks++;
        if (outs() !== '0) begin errors++; $display("FAIL idle_after_reset got %h exp 0", outs()); end
        $display("reset: outputs %h", outs());
    endtask

    task automatic test_solve(input string name, input logic [31:0] rsold,
                              input logic [31:0] rs[$], input int order);
        logic [2:0] exp_flags;
        int exp_lat;
        model(rsold, rs);
        drive_solve(rsold, rs, order, -1, -1);
        exp_flags = {exp_kind == K_CONV, exp_kind == K_MAX, exp_kind == K_NAN};
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL %s done got %b exp 1", name, bus.done); end
        checks++;
        if ({bus.converged, bus.max_iter_reached, bus.nan_error} !== exp_flags) begin
            errors++;
            $display("FAIL %s status conv/max/nan got %b exp %b", name,
                     {bus.converged, bus.max_iter_reached, bus.nan_error}, exp_flags);
        end
        checks++;
        if (bus.iteration_count !== ITER_W'(exp_iters)) begin
            errors++; $display("FAIL %s iteration_count got %0d exp %0d", name, bus.iteration_count, exp_iters);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b exp 0", name, bus.busy); end
        checks++;
        if (obs_div_cnt != exp_old.size()) begin
            errors++; $display("FAIL %s div2_pulses got %0d exp %0d", name, obs_div_cnt, exp_old.size());
        end
        for (int i = 0; i < exp_old.size() && i < obs_old.size(); i++) begin
            checks++;
            if (obs_old[i] !== exp_old[i] || obs_new[i] !== exp_new[i]) begin
                errors++;
                $display("FAIL %s div_operands iter %0d got %h/%h exp %h/%h", name, i,
                         obs_old[i], obs_new[i], exp_old[i], exp_new[i]);
            end
        end
        checks++;
        if (obs_start_sr !== 1'b1) begin errors++; $display("FAIL %s start_latency stage_reset got %b exp 1", name, obs_start_sr); end
        for (int i = 0; i < obs_sr_len.size(); i++) begin
            checks++;
            if (obs_sr_len[i] != SRC) begin
                errors++; $display("FAIL %s stage_reset_len iter %0d got %0d exp %0d", name, i, obs_sr_len[i], SRC);
            end
        end
        for (int i = 0; i < obs_lat.size(); i++) begin
            exp_lat = (i == 0 && order != 0) ? 2 : 1;
            checks++;
            if (obs_lat[i] != exp_lat) begin
                errors++; $display("FAIL %s check_latency iter %0d got %0d exp %0d", name, i, obs_lat[i], exp_lat);
            end
        end
        checks++;
        if (bus.rsold_out !== exp_rsold_fin || bus.rsnew_out !== exp_rsnew_fin) begin
            errors++;
            $display("FAIL %s final_operands got %h/%h exp %h/%h", name,
                     bus.rsold_out, bus.rsnew_out, exp_rsold_fin, exp_rsnew_fin);
        end
        $display("solve %s: order %0d kind %0d iters %0d div2 %0d", name, order, exp_kind, exp_iters, obs_div_cnt);
    endtask

    task automatic test_directed();
        logic [31:0] rs[$];
        rs.delete(); rs.push_back(32'h20000000);
        test_solve("converge_iter0", 32'h3F800000, rs, 0);
        rs.delete(); rs.push_back(32'h3F800000); rs.push_back(32'h3E800000); rs.push_back(32'h00000000);
        test_solve("three_iter", 32'h3F800000, rs, 0);
        rs.delete(); repeat (MAX_ITER) rs.push_back(32'h3F800000);
        test_solve("max_iter", 32'h3F800000, rs, 0);
        rs.delete(); rs.push_back(32'h7FC00000);
        test_solve("nan", 32'h3F800000, rs, 0);
        rs.delete(); rs.push_back(32'h80000000);
        test_solve("neg_zero", 32'h3F800000, rs, 0);
        rs.delete(); rs.push_back(32'h283424DC); rs.push_back(32'h7F800000); rs.push_back(32'h283424DB);
        test_solve("tol_edge_inf", 32'h40000000, rs, 0);
    endtask

    task automatic test_event_order();
        logic [31:0] rs[$];
        rs.delete(); rs.push_back(32'h3F000000); rs.push_back(32'h00001234);
        test_solve("rsnew_first", 32'h3F800000, rs, 1);
        rs.delete(); rs.push_back(32'h3F000000); rs.push_back(32'h80000001);
        test_solve("simultaneous", 32'h3F800000, rs, 2);
    endtask

    task automatic test_abort_pupd();
        logic [31:0] rs[$];
        rs.delete(); repeat (MAX_ITER) rs.push_back(rand_large());
        drive_solve(32'h3F800000, rs, 0, -1, 1);
        checks++;
        if ({bus.busy, bus.done, bus.div2_start, bus.stage_reset} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_state busy/done/div2/sr got %b exp 0000",
                     {bus.busy, bus.done, bus.div2_start, bus.stage_reset});
        end
        checks++;
        if (bus.rsold_out !== rs[0] || bus.rsnew_out !== rs[1]) begin
            errors++;
            $display("FAIL abort_hold got %h/%h exp %h/%h", bus.rsold_out, bus.rsnew_out, rs[0], rs[1]);
        end
        bus.solve_start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.solve_start = 1'b0;
        bus.abort = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.stage_reset !== 1'b0) begin
            errors++;
            $display("FAIL abort_wins got busy=%b stage_reset=%b exp 0/0", bus.busy, bus.stage_reset);
        end
        $display("abort: rsold_out %h rsnew_out %h", bus.rsold_out, bus.rsnew_out);
    endtask

    task automatic test_reset_mid_solve();
        logic [31:0] rs[$];
        rs.delete(); repeat (MAX_ITER) rs.push_back(rand_large());
        drive_solve(32'h3F800000, rs, 0, 3, -1);
        checks++;
        if (bus.iteration_count !== ITER_W'(3) || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_solve_state got count=%0d busy=%b exp 3/1", bus.iteration_count, bus.busy);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (outs() !== '0) begin errors++; $display("FAIL async_reset got %h exp 0", outs()); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (outs() !== '0) begin errors++; $display("FAIL after_reset_release got %h exp 0", outs()); end
        $display("reset_mid_solve: outputs %h", outs());
    endtask

    task automatic test_random();
        logic [31:0] rs[$];
        for (int n = 0; n < 25; n++) begin
            rs.delete();
            for (int k = 0; k < MAX_ITER; k++) rs.push_back(rand_val());
            test_solve("random", rand_large(), rs, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        bus.solve_start     = 1'b0;
        bus.abort           = 1'b0;
        bus.rsold_finish    = 1'b0;
        bus.rsold_in        = '0;
        bus.rsnew_finish    = 1'b0;
        bus.rsnew_in        = '0;
        bus.p_update_finish = 1'b0;
        test_reset();
        test_directed();
        test_event_order();
        test_abort_pupd();
        test_reset_mid_solve();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
